// File: rtl/int_to_float_param.sv
// Streaming integer to IEEE-754 single converter (round-to-nearest-even), fixed 3-edge latency, stb/ack both sides.
// Busy NORM/ROUND/PUT_Z ignores input_a; result held until acked. ITOF_INEXACT_EN adds output_inexact.
module int_to_float_param #(
  parameter int INT_WIDTH = 32,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INT_WIDTH-1:0] input_a,
  input  logic                 input_a_stb,
  output logic                 input_a_ack,
  output logic [31:0]          output_z,
  output logic                 output_z_stb,
`ifdef ITOF_INEXACT_EN
  output logic                 output_inexact,
`endif
  input  logic                 output_z_ack
);

  typedef enum logic [1:0] {GET_A, NORM, ROUND, PUT_Z} state_t;

  state_t               state;
  logic [INT_WIDTH-1:0] a_q;
  logic                 sign_q;
  logic                 zero_q;
  logic [7:0]           exp_q;
  logic [63:0]          work_q;

  logic                 sign_c;
  logic [INT_WIDTH-1:0] mag_c;
  logic [5:0]           msb_c;
  logic [63:0]          just_c;

  always_comb begin
    sign_c = SIGNED ? a_q[INT_WIDTH-1] : 1'b0;
    mag_c  = sign_c ? -a_q : a_q;
    msb_c  = '0;
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (mag_c[i]) msb_c = 6'(i);
    end
    just_c = 64'(mag_c) << (6'd63 - msb_c);
  end

  logic [23:0] mant_c;
  logic        guard_c;
  logic        sticky_c;
  logic        inc_c;
  logic [24:0] mant_rnd_c;
  logic [30:0] mag_bits_c;

  always_comb begin
    mant_c     = work_q[63:40];
    guard_c    = work_q[39];
    sticky_c   = |work_q[38:0];
    inc_c      = guard_c & (sticky_c | mant_c[0]);
    mant_rnd_c = {1'b0, mant_c} + {24'd0, inc_c};
    // Hidden bit adds into the exponent field, so a rounding carry-out bumps exp and zeroes the fraction.
    mag_bits_c = {exp_q - 8'd1, 23'd0} + {6'd0, mant_rnd_c};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= GET_A;
      input_a_ack    <= 1'b1;
      output_z_stb   <= 1'b0;
      output_z       <= 32'h0;
      a_q            <= '0;
      sign_q         <= 1'b0;
      zero_q         <= 1'b0;
      exp_q          <= 8'd0;
      work_q         <= 64'd0;
`ifdef ITOF_INEXACT_EN
      output_inexact <= 1'b0;
`endif
    end else begin
      case (state)
        GET_A: begin
          if (input_a_stb && input_a_ack) begin
            a_q         <= input_a;
            input_a_ack <= 1'b0;
            state       <= NORM;
          end
        end
        NORM: begin
          sign_q <= sign_c;
          zero_q <= (mag_c == '0);
          exp_q  <= 8'd127 + {2'd0, msb_c};
          work_q <= just_c;
          state  <= ROUND;
        end
        ROUND: begin
          output_z       <= zero_q ? 32'h0 : {sign_q, mag_bits_c};
          output_z_stb   <= 1'b1;
`ifdef ITOF_INEXACT_EN
          output_inexact <= guard_c | sticky_c;
`endif
          state          <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_param.sv
// Scoreboard bench for int_to_float_param: queue of expected results checked by a negedge monitor,
// reference is an arithmetic quotient/remainder rounding model; extra instances cover other widths.
module tb_int_to_float_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'h0;
  logic        a_stb = 1'b0;
  logic        a_ack;
  logic [31:0] z;
  logic        z_stb;
  logic        z_ack = 1'b0;

  logic [31:0] a_u32 = 32'h0;
  logic [7:0]  a_s8 = 8'h0;
  logic [63:0] a_u64 = 64'h0;
  logic        x_stb = 1'b0;
  logic        ack_u32, ack_s8, ack_u64;
  logic        stb_u32, stb_s8, stb_u64;
  logic [31:0] z_u32, z_s8, z_u64;
`ifdef ITOF_INEXACT_EN
  logic        inexact, inx_u32, inx_s8, inx_u64;
`endif

  typedef struct {
    logic [31:0] z;
    bit          inx;
    int          cap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   hold_ack = 1'b0;

  int_to_float_param #(.INT_WIDTH(32), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(a_ack),
    .output_z(z), .output_z_stb(z_stb),
`ifdef ITOF_INEXACT_EN
    .output_inexact(inexact),
`endif
    .output_z_ack(z_ack));

  int_to_float_param #(.INT_WIDTH(32), .SIGNED(1'b0)) u_u32 (
    .clk(clk), .rst(rst), .input_a(a_u32), .input_a_stb(x_stb), .input_a_ack(ack_u32),
    .output_z(z_u32), .output_z_stb(stb_u32),
`ifdef ITOF_INEXACT_EN
    .output_inexact(inx_u32),
`endif
    .output_z_ack(1'b1));

  int_to_float_param #(.INT_WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .input_a(a_s8), .input_a_stb(x_stb), .input_a_ack(ack_s8),
    .output_z(z_s8), .output_z_stb(stb_s8),
`ifdef ITOF_INEXACT_EN
    .output_inexact(inx_s8),
`endif
    .output_z_ack(1'b1));

  int_to_float_param #(.INT_WIDTH(64), .SIGNED(1'b0)) u_u64 (
    .clk(clk), .rst(rst), .input_a(a_u64), .input_a_stb(x_stb), .input_a_ack(ack_u64),
    .output_z(z_u64), .output_z_stb(stb_u64),
`ifdef ITOF_INEXACT_EN
    .output_inexact(inx_u64),
`endif
    .output_z_ack(1'b1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    z_ack = hold_ack ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Value = q * 2^sh + r; round q by comparing r against half a unit.
  function automatic void model(input logic [63:0] raw, input int w, input bit sgn,
                                output logic [31:0] zo, output bit inx);
    logic [63:0] mask, v, mag, q, r, half;
    bit neg;
    int n, sh;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v    = raw & mask;
    neg  = sgn && v[w-1];
    mag  = neg ? ((~v + 64'd1) & mask) : v;
    zo   = 32'h0;
    inx  = 1'b0;
    if (mag == 64'd0) return;
    n = 63;
    while (!mag[n]) n--;
    if (n <= 23) begin
      q = mag << (23 - n);
    end else begin
      sh   = n - 23;
      q    = mag >> sh;
      r    = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (r != 64'd0);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        n++;
      end
    end
    zo = {neg, 8'(127 + n), q[22:0]};
  endfunction

  logic        prev_stb = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_z = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stb <= 1'b0;
    end else begin
      if (z_stb && !prev_stb) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got z=%h with no pending conversion", z);
        end else begin
          chk("latency", 64'(cyc), 64'(sb_q[0].cap + 2));
        end
      end
      if (z_stb && prev_stb && !prev_ack) chk("hold_z", 64'(z), 64'(prev_z));
      if (z_stb) chk("in_ack_busy", 64'(a_ack), 64'd0);
      if (z_stb && z_ack && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("z", 64'(z), 64'(e.z));
`ifdef ITOF_INEXACT_EN
        chk("inexact", 64'(inexact), 64'(e.inx));
`endif
      end
      prev_stb <= z_stb;
      prev_ack <= z_ack;
      prev_z   <= z;
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] ez, input bit einx, input bit push);
    bit done = 1'b0;
    a     = v;
    a_stb = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (a_ack) begin
        if (push) sb_q.push_back('{z: ez, inx: einx, cap: cyc + 1});
        done = 1'b1;
      end
    end
    chk("send_accept", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    a_stb = 1'b0;
    a     = $urandom;
  endtask

  task automatic send_model(input logic [31:0] v);
    logic [31:0] ez;
    bit ei;
    model(64'(v), 32, 1'b1, ez, ei);
    send(v, ez, ei, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !z_stb;
    end
    chk("idle", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_extra(input logic [31:0] v32, input logic [7:0] v8, input logic [63:0] v64,
                           input logic [31:0] e32, input logic [31:0] e8, input logic [31:0] e64);
    bit ok = 1'b0;
    bit g32 = 1'b0, g8 = 1'b0, g64 = 1'b0;
    logic [31:0] r32 = 32'h0, r8 = 32'h0, r64 = 32'h0;
    a_u32 = v32;
    a_s8  = v8;
    a_u64 = v64;
    x_stb = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = ack_u32 && ack_s8 && ack_u64;
    end
    chk("extra_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    x_stb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stb_u32 && !g32) begin g32 = 1'b1; r32 = z_u32; end
      if (stb_s8 && !g8) begin g8 = 1'b1; r8 = z_s8; end
      if (stb_u64 && !g64) begin g64 = 1'b1; r64 = z_u64; end
    end
    chk("u32_z", {31'd0, g32, r32}, {31'd0, 1'b1, e32});
    chk("s8_z", {31'd0, g8, r8}, {31'd0, 1'b1, e8});
    chk("u64_z", {31'd0, g64, r64}, {31'd0, 1'b1, e64});
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_v[8]   = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                              32'd16777217, 32'd16777219, 32'd16777218};
  logic [31:0] dir_z[8]   = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'hCF000000,
                              32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4B800001};
  bit          dir_inx[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] v, e32, e8, e64;
    logic [63:0] w64;
    logic [7:0]  w8;
    bit          ei, bp_seen;
    int          k;

    #2 rst = 1'b0;
    #10;
    chk("rst_in_ack", 64'(a_ack), 64'd1);
    chk("rst_z_stb", 64'(z_stb), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
`ifdef ITOF_INEXACT_EN
    chk("rst_inexact", 64'(inexact), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    run_extra(32'hFFFFFFFF, 8'h80, 64'hFFFFFFFFFFFFFFFF, 32'h4F800000, 32'hC3000000, 32'h5F800000);
    for (int i = 0; i < 12; i++) begin
      v   = $urandom >> $urandom_range(0, 31);
      w8  = 8'($urandom);
      w64 = {$urandom, $urandom} >> $urandom_range(0, 63);
      model(64'(v), 32, 1'b0, e32, ei);
      model(64'(w8), 8, 1'b1, e8, ei);
      model(w64, 64, 1'b0, e64, ei);
      run_extra(v, w8, w64, e32, e8, e64);
    end

    for (int i = 0; i < 8; i++) send(dir_v[i], dir_z[i], dir_inx[i], 1'b1);

    wait_idle();
    hold_ack = 1'b1;
    @(posedge clk);
    #2;
    send(32'd1, 32'h3F800000, 1'b0, 1'b1);
    a     = 32'd5;
    a_stb = 1'b1;
    bp_seen = 1'b0;
    for (int i = 0; i < 10 && !bp_seen; i++) begin
      @(negedge clk);
      bp_seen = z_stb;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_stb", 64'(z_stb), 64'd1);
      chk("bp_z", 64'(z), 64'h3F800000);
      chk("bp_in_ack", 64'(a_ack), 64'd0);
      @(negedge clk);
    end
    hold_ack = 1'b0;
    send(32'd5, 32'h40A00000, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v = v >> $urandom_range(0, 31);
        1: v = -(v >> $urandom_range(0, 31));
        2: begin
          k = $urandom_range(1, 7);
          v = ((32'h800000 | ($urandom & 32'h7FFFFF)) << k) | (32'd1 << (k - 1));
          if ($urandom_range(0, 1) == 1) v = -v;
        end
        default: ;
      endcase
      send_model(v);
    end

    wait_idle();
    send(32'd1, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_in_ack", 64'(a_ack), 64'd1);
    chk("mid_rst_z_stb", 64'(z_stb), 64'd0);
    chk("mid_rst_z", 64'(z), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(z_stb), 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'd1, 32'h3F800000, 1'b0, 1'b1);

    wait_idle();
    chk("drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
